rrv64_l1d_store_buffer: RTL and testbench

RRV64_L1D_STORE_BUFFER -- requirements
Module: rrv64_l1d_store_buffer

---
 rtl/rrv64_l1d_store_buffer.sv | 168 ++++++++++++++++
 tb/tb_rrv64_l1d_store_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rrv64_l1d_store_buffer.sv
// L1D store buffer: circular FIFO of pending stores with youngest-match load forwarding and flush.
// Optional macro RRV64_STB_COALESCE_EN merges a store into the youngest (non-head) entry.
module rrv64_l1d_store_buffer #(
  parameter int unsigned STB_D  = 16,
  parameter int unsigned ADDR_W = 56,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [ADDR_W-1:0]        enq_addr_i,
  input  logic [DATA_W-1:0]        enq_data_i,
  input  logic [DATA_W/8-1:0]      enq_mask_i,
  output logic                     drain_valid_o,
  input  logic                     drain_ready_i,
  output logic [ADDR_W-1:0]        drain_addr_o,
  output logic [DATA_W-1:0]        drain_data_o,
  output logic [DATA_W/8-1:0]      drain_mask_o,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DATA_W-1:0]        ld_data_o,
  output logic [DATA_W/8-1:0]      ld_mask_o,
  input  logic                     flush_req_i,
  output logic                     flush_done_o,
  output logic [$clog2(STB_D):0]   count_o
);

  localparam int unsigned PtrW  = $clog2(STB_D);
  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(MaskW);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(STB_D);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:OffW] == b[ADDR_W-1:OffW];
  endfunction

  logic [ADDR_W-1:0] addr_q [STB_D];
  logic [DATA_W-1:0] data_q [STB_D];
  logic [MaskW-1:0]  mask_q [STB_D];
  logic [STB_D-1:0]  valid_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [PtrW:0]     count_q, count_d;
  state_e            state_q, state_d;
  logic              flush_done_q, flush_done_d;

  logic coal_hit, enq_fire, alloc, drain_fire;

  // Low address bits only select a byte within the word, so forwarding ignores them.
  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr_i;

`ifdef RRV64_STB_COALESCE_EN
  logic [PtrW-1:0] youngest;
  assign youngest = tail_q - PtrW'(1);
  // count >= 2 keeps the youngest entry distinct from the head being presented to the L1D.
  assign coal_hit = (count_q >= (PtrW + 1)'(2)) && word_match(addr_q[youngest], enq_addr_i);
`else
  assign coal_hit = 1'b0;
`endif

  assign enq_ready_o   = ((count_q < Full) || coal_hit) && (state_q == StIdle);
  assign enq_fire      = enq_valid_i && enq_ready_o;
  assign alloc         = enq_fire && !coal_hit;
  assign drain_valid_o = (count_q != '0);
  assign drain_fire    = drain_valid_o && drain_ready_i;
  assign count_o       = count_q;
  assign flush_done_o  = flush_done_q;

  always_comb begin
    count_d = count_q;
    if (alloc && !drain_fire) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!alloc && drain_fire) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_req_i) state_d = StFlush;
      end
      StFlush: begin
        if (count_q == '0) begin
          state_d      = StIdle;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      state_q      <= StIdle;
      flush_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (drain_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
    end
  end

  // Payload needs no reset: every read of it is qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alloc) begin
        addr_q[tail_q] <= enq_addr_i;
        data_q[tail_q] <= enq_data_i;
        mask_q[tail_q] <= enq_mask_i;
      end
`ifdef RRV64_STB_COALESCE_EN
      if (enq_fire && coal_hit) begin
        for (int unsigned b = 0; b < MaskW; b++) begin
          if (enq_mask_i[b]) data_q[youngest][8*b +: 8] <= enq_data_i[8*b +: 8];
        end
        mask_q[youngest] <= mask_q[youngest] | enq_mask_i;
      end
`endif
    end
  end

  always_comb begin
    drain_addr_o = '0;
    drain_data_o = '0;
    drain_mask_o = '0;
    if (drain_valid_o) begin
      drain_addr_o = addr_q[head_q];
      drain_data_o = data_q[head_q];
      drain_mask_o = mask_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    ld_mask_o = '0;
    for (int unsigned i = 0; i < STB_D; i++) begin
      idx = head_q + PtrW'(i);
      if (valid_q[idx] && word_match(addr_q[idx], ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[idx];
        ld_mask_o = mask_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_rrv64_l1d_store_buffer.sv
// Directed bench for rrv64_l1d_store_buffer with a drain scoreboard; follows RRV64_STB_COALESCE_EN.
module tb_rrv64_l1d_store_buffer;

  localparam int unsigned STB_D  = 16;
  localparam int unsigned ADDR_W = 56;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        mask;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq_valid_i = 1'b0;
  logic              enq_ready_o;
  logic [ADDR_W-1:0] enq_addr_i = '0;
  logic [DATA_W-1:0] enq_data_i = '0;
  logic [7:0]        enq_mask_i = '0;
  logic              drain_valid_o;
  logic              drain_ready_i = 1'b0;
  logic [ADDR_W-1:0] drain_addr_o;
  logic [DATA_W-1:0] drain_data_o;
  logic [7:0]        drain_mask_o;
  logic [ADDR_W-1:0] ld_addr_i = '0;
  logic              ld_hit_o;
  logic [DATA_W-1:0] ld_data_o;
  logic [7:0]        ld_mask_o;
  logic              flush_req_i = 1'b0;
  logic              flush_done_o;
  logic [4:0]        count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  rrv64_l1d_store_buffer #(.STB_D(STB_D), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i), .enq_mask_i(enq_mask_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o), .drain_mask_o(drain_mask_o),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_mask_o(ld_mask_o),
    .flush_req_i(flush_req_i), .flush_done_o(flush_done_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [7:0] m);
    enq_valid_i = 1'b1;
    enq_addr_i  = a;
    enq_data_i  = d;
    enq_mask_i  = m;
    step();
    enq_valid_i = 1'b0;
  endtask

  task automatic drain_all();
    drain_ready_i = 1'b1;
    for (int i = 0; i < 40 && count_o != 0; i++) step();
    drain_ready_i = 1'b0;
    chk("drain_all_count", 64'(count_o), 64'd0);
    chk("drain_all_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: occupancy check, then pop on drain and push/merge on enqueue, at negedge.
  always @(negedge clk) begin
    if (!rst) begin
      ent_t e;
      chk("count_vs_model", 64'(count_o), 64'(sb.size()));
      if (drain_valid_o && drain_ready_i) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("drain_addr", 64'(drain_addr_o), 64'(e.addr));
          chk("drain_data", drain_data_o, e.data);
          chk("drain_mask", 64'(drain_mask_o), 64'(e.mask));
        end
      end
      if (enq_valid_i && enq_ready_o) begin
`ifdef RRV64_STB_COALESCE_EN
        if (sb.size() >= 2 && sb[$].addr[ADDR_W-1:3] == enq_addr_i[ADDR_W-1:3]) begin
          e = sb.pop_back();
          for (int b = 0; b < 8; b++)
            if (enq_mask_i[b]) e.data[8*b +: 8] = enq_data_i[8*b +: 8];
          e.mask = e.mask | enq_mask_i;
          sb.push_back(e);
        end else
`endif
        sb.push_back('{addr: enq_addr_i, data: enq_data_i, mask: enq_mask_i});
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d5;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    chk("rst_drain_valid", 64'(drain_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ld_hit", 64'(ld_hit_o), 64'd0);
    chk("rst_flush_done", 64'(flush_done_o), 64'd0);
    chk("rst_drain_addr", 64'(drain_addr_o), 64'd0);

    // Fill with 16 distinct words, drain stalled.
    d5 = '0;
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] d;
      d = {$urandom(), $urandom()};
      if (i == 5) d5 = d;
      enq(56'h1000 + 56'(i * 8), d, 8'hFF);
    end
    chk("full_count", 64'(count_o), 64'd16);
    chk("full_enq_ready", 64'(enq_ready_o), 64'd0);
    chk("full_drain_valid", 64'(drain_valid_o), 64'd1);
    ld_addr_i = 56'h1000 + 56'd40 + 56'd3;
    #1;
    chk("fwd_full_hit", 64'(ld_hit_o), 64'd1);
    chk("fwd_full_data", ld_data_o, d5);

    // Full: simultaneous drain and enqueue attempt -> enqueue refused.
    enq_valid_i   = 1'b1;
    enq_addr_i    = 56'h2000;
    enq_data_i    = 64'hDEAD;
    enq_mask_i    = 8'hFF;
    drain_ready_i = 1'b1;
    #1;
    chk("full_bypass_ready", 64'(enq_ready_o), 64'd0);
    step();
    enq_valid_i   = 1'b0;
    drain_ready_i = 1'b0;
    #1;
    chk("after_drain_count", 64'(count_o), 64'd15);
    chk("after_drain_ready", 64'(enq_ready_o), 64'd1);
    drain_all();

    // Youngest-match forwarding.
    enq(56'h100, 64'h11, 8'h01);
    enq(56'h100, 64'h2200, 8'h02);
    ld_addr_i = 56'h104;
    #1;
    chk("fwd_young_hit", 64'(ld_hit_o), 64'd1);
    chk("fwd_young_data", ld_data_o, 64'h2200);
    chk("fwd_young_mask", 64'(ld_mask_o), 64'h02);
    chk("fwd_young_count", 64'(count_o), 64'd2);
    ld_addr_i = 56'h108;
    #1;
    chk("fwd_miss_hit", 64'(ld_hit_o), 64'd0);
    chk("fwd_miss_data", ld_data_o, 64'd0);
    chk("fwd_miss_mask", 64'(ld_mask_o), 64'd0);
    drain_all();

    // Same word as the youngest entry: merged when coalescing, otherwise a new entry.
    enq(56'h0, 64'h55, 8'hFF);
    enq(56'h40, 64'h0000_0000_1122_3344, 8'h0F);
    enq(56'h40, 64'hAABB_CCDD_0000_0000, 8'hF0);
    ld_addr_i = 56'h40;
    #1;
`ifdef RRV64_STB_COALESCE_EN
    chk("coal_count", 64'(count_o), 64'd2);
    chk("coal_mask", 64'(ld_mask_o), 64'hFF);
    chk("coal_data", ld_data_o, 64'hAABB_CCDD_1122_3344);
`else
    chk("nocoal_count", 64'(count_o), 64'd3);
    chk("nocoal_mask", 64'(ld_mask_o), 64'hF0);
    chk("nocoal_data", ld_data_o, 64'hAABB_CCDD_0000_0000);
`endif
    drain_all();

    // Flush of 3 entries with the drain open.
    enq(56'h300, 64'h1, 8'h01);
    enq(56'h308, 64'h2, 8'h01);
    enq(56'h310, 64'h3, 8'h01);
    flush_req_i   = 1'b1;
    drain_ready_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_enq_ready", 64'(enq_ready_o), 64'd0);
      chk("flush_done_early", 64'(flush_done_o), 64'd0);
      step();
    end
    chk("flush_done_pulse", 64'(flush_done_o), 64'd1);
    chk("flush_end_ready", 64'(enq_ready_o), 64'd1);
    step();
    chk("flush_done_once", 64'(flush_done_o), 64'd0);
    drain_ready_i = 1'b0;

    // Flush with an empty buffer.
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    chk("eflush_enq_ready", 64'(enq_ready_o), 64'd0);
    chk("eflush_done_early", 64'(flush_done_o), 64'd0);
    step();
    chk("eflush_done", 64'(flush_done_o), 64'd1);
    step();
    chk("eflush_done_once", 64'(flush_done_o), 64'd0);

    // Reset in the middle of a stalled flush.
    enq(56'h500, 64'h7, 8'h01);
    enq(56'h508, 64'h8, 8'h01);
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    step();
    chk("rflush_enq_ready", 64'(enq_ready_o), 64'd0);
    chk("rflush_count", 64'(count_o), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rflush_count_zero", 64'(count_o), 64'd0);
    chk("rflush_enq_ready1", 64'(enq_ready_o), 64'd1);
    chk("rflush_drain_valid", 64'(drain_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rflush_no_done", 64'(flush_done_o), 64'd0);
      step();
    end
    ld_addr_i = 56'h500;
    #1;
    chk("rflush_ld_miss", 64'(ld_hit_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
